// File: rtl/sprite_fetch_pkg.sv
// Shared display constants and helpers for the sprite fetch stage.
package sprite_fetch_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t TRANSP_DEFAULT = 8'hE3;

    // Width of a counter holding 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// Sprite ROM bus: registered address out, data and address echo back one cycle later.
interface sprite_fetch_if #(
    parameter int unsigned ADDRW  = 10,
    parameter int unsigned DATA_W = 8
);

    logic [ADDRW-1:0]  rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDRW-1:0]  rom_addr_echo;

    modport master (
        output rom_addr,
        input  rom_data,
        input  rom_addr_echo
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output rom_addr_echo
    );

endinterface

// File: rtl/sprite_fetch_anim_counter.sv
// Vsync divider and animation frame counter; frame steps once every ANIM_DIV vsync pulses.
module sprite_fetch_anim_counter
    import sprite_fetch_pkg::*;
#(
    parameter int unsigned FRAMES   = 4,
    parameter int unsigned ANIM_DIV = 8,
    localparam int unsigned FRM_W   = clog2_min1(FRAMES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_vsync_pulse,
    output logic [FRM_W-1:0] o_anim_frame,
    output logic             o_frame_step
);

    localparam int unsigned DIV_W = clog2_min1(ANIM_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FRAMES - 1);

    logic [DIV_W-1:0] r_div;
    logic [FRM_W-1:0] r_frame;

    always_comb begin
        o_frame_step = i_vsync_pulse && (r_div == DIV_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div   <= '0;
            r_frame <= '0;
        end else if (i_vsync_pulse) begin
            if (r_div == DIV_LAST) begin
                r_div   <= '0;
                r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_anim_frame = r_frame;

endmodule

// File: rtl/sprite_fetch.sv
// Raster position to sprite ROM address, then ROM data to colour/valid, fixed 3-cycle latency.
module sprite_fetch
    import sprite_fetch_pkg::*;
#(
    parameter int unsigned SPR_W    = 16,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned FRAMES   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ANIM_DIV = 8,
    parameter logic [DATA_W-1:0] TRANSP = DATA_W'(TRANSP_DEFAULT),
    localparam int unsigned ADDRW   = $clog2(SPR_W * SPR_H * FRAMES),
    localparam int unsigned FRM_W   = clog2_min1(FRAMES)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COORD_W-1:0] i_hcount,
    input  logic [COORD_W-1:0] i_vcount,
    input  logic               i_bright,
    input  logic               i_vsync_pulse,
    input  logic [COORD_W-1:0] i_sprite_x,
    input  logic [COORD_W-1:0] i_sprite_y,
    input  logic               i_sprite_en,
    sprite_fetch_if.master     io_rom,
    output logic [DATA_W-1:0]  o_pix_color,
    output logic               o_pix_valid,
    output logic [FRM_W-1:0]   o_anim_frame,
    output logic               o_addr_err,
    output logic               o_frame_step
);

    localparam int unsigned COL_W = $clog2(SPR_W);
    localparam int unsigned ROW_W = $clog2(SPR_H);
    localparam int unsigned EXT_W = COORD_W + 1;

    logic [COORD_W-1:0] r_sx;
    logic [COORD_W-1:0] r_sy;
    logic               r_en;

    logic [EXT_W-1:0]   w_sx_end;
    logic [EXT_W-1:0]   w_sy_end;
    logic               w_hit;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [ADDRW-1:0]   w_addr;
    logic [FRM_W-1:0]   w_anim_frame;
    logic               w_opaque;

    logic [ADDRW-1:0]   r_rom_addr;
    logic [ADDRW-1:0]   r_exp_addr;
    logic [ADDRW-1:0]   r_exp_d2;
    logic               r_hit_d1;
    logic               r_hit_d2;
    logic [DATA_W-1:0]  r_pix_color;
    logic               r_pix_valid;
    logic               r_addr_err;

    sprite_fetch_anim_counter #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_vsync_pulse (i_vsync_pulse),
        .o_anim_frame  (w_anim_frame),
        .o_frame_step  (o_frame_step)
    );

    // Box ends are one bit wider than coordinates so a sprite near 1023 clips instead of wrapping.
    always_comb begin
        w_sx_end = {1'b0, r_sx} + EXT_W'(SPR_W);
        w_sy_end = {1'b0, r_sy} + EXT_W'(SPR_H);
        w_hit    = r_en && i_bright
                   && (i_hcount >= r_sx) && ({1'b0, i_hcount} < w_sx_end)
                   && (i_vcount >= r_sy) && ({1'b0, i_vcount} < w_sy_end);
        w_col    = COL_W'(i_hcount - r_sx);
        w_row    = ROW_W'(i_vcount - r_sy);
        w_addr   = ADDRW'({w_anim_frame, w_row, w_col});
        w_opaque = r_hit_d2 && (io_rom.rom_data != TRANSP);
    end

    // Position is only taken at vsync so a mid-frame move never tears the sprite.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sx <= '0;
            r_sy <= '0;
            r_en <= 1'b0;
        end else if (i_vsync_pulse) begin
            r_sx <= i_sprite_x;
            r_sy <= i_sprite_y;
            r_en <= i_sprite_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr  <= '0;
            r_exp_addr  <= '0;
            r_exp_d2    <= '0;
            r_hit_d1    <= 1'b0;
            r_hit_d2    <= 1'b0;
            r_pix_color <= '0;
            r_pix_valid <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            if (w_hit) begin
                r_rom_addr <= w_addr;
                r_exp_addr <= w_addr;
            end
            r_hit_d1    <= w_hit;
            r_hit_d2    <= r_hit_d1;
            r_exp_d2    <= r_exp_addr;
            r_pix_valid <= w_opaque;
            r_pix_color <= w_opaque ? io_rom.rom_data : '0;
            if (r_hit_d2 && (io_rom.rom_addr_echo != r_exp_d2)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign io_rom.rom_addr = r_rom_addr;
    assign o_pix_color     = r_pix_color;
    assign o_pix_valid     = r_pix_valid;
    assign o_anim_frame    = w_anim_frame;
    assign o_addr_err      = r_addr_err;

endmodule
